alu_wb_stage: RTL

//  Writeback stage directly downstream of the combinational ALU/shifter. Registers the ALU

---
 rtl/alu_wb_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// Writeback stage: 2-entry skid buffer between ALU and register-file write port, plus
// NZVC status register and saturating overflow counter. Optional ALU_WB_SAT_EN saturates ADD/SUB overflow.
module alu_wb_stage #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [DW-1:0]    in_result,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic             in_overflow,
  input  logic             in_carry,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_rf_we,
  input  logic             in_flags_we,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RW-1:0]    wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic             wb_we,
  output logic [3:0]       status,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count,
  output logic             sat_sticky
);

  logic          push;
  logic          pop;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;
  logic          head_reg;
  logic          tail_reg;
  logic [DW-1:0] data_mem [2];
  logic [RW-1:0] rd_mem [2];
  logic [1:0]    we_mem;
  logic [DW-1:0] store_data;
  logic [3:0]    flags;

  assign push       = in_valid & in_ready;
  assign pop        = wb_valid & wb_ready;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

`ifdef ALU_WB_SAT_EN
  logic          sat_hit;
  logic [DW-1:0] sat_value;

  assign sat_hit    = ((in_opcode == 4'd0) || (in_opcode == 4'd1)) && in_overflow;
  // A negative wrapped result means positive overflow, so clamp to the maximum.
  assign sat_value  = in_result[DW-1] ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
  assign store_data = sat_hit ? sat_value : in_result;
  assign flags      = sat_hit ? {store_data[DW-1], (store_data == '0), 1'b1, in_carry}
                              : {in_negative, in_zero, in_overflow, in_carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_sticky <= 1'b0;
    else if (clr_count)
      sat_sticky <= 1'b0;
    else if (push && sat_hit)
      sat_sticky <= 1'b1;
  end
`else
  logic [3:0] unused_opcode;

  assign unused_opcode = in_opcode;
  assign store_data    = in_result;
  assign flags         = {in_negative, in_zero, in_overflow, in_carry};
  assign sat_sticky    = 1'b0;
`endif

  // in_ready and wb_valid come from the next occupancy, so neither depends on wb_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      in_ready  <= 1'b1;
      wb_valid  <= 1'b0;
    end else begin
      count_reg <= count_next;
      in_ready  <= (count_next != 2'd2);
      wb_valid  <= (count_next != 2'd0);
      if (push)
        tail_reg <= ~tail_reg;
      if (pop)
        head_reg <= ~head_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_mem[gi] <= '0;
          rd_mem[gi]   <= '0;
          we_mem[gi]   <= 1'b0;
        end else if (push && (tail_reg == 1'(gi))) begin
          data_mem[gi] <= store_data;
          rd_mem[gi]   <= in_rd;
          we_mem[gi]   <= in_rf_we;
        end
      end
    end
  endgenerate

  assign wb_data = data_mem[head_reg];
  assign wb_rd   = rd_mem[head_reg];
  assign wb_we   = we_mem[head_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      status <= 4'b0000;
    else if (push && in_flags_we)
      status <= flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_count <= '0;
    else if (clr_count)
      ovf_count <= '0;
    else if (push && in_overflow && (ovf_count != {CNT_W{1'b1}}))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule
